// File: rtl/sp_mem_bist.sv
// March-test BIST engine for a single-port memory with byte strobes and one-cycle read latency.
// Runs w(P); up r(P)w(~P); down r(~P)w(P); up r(P) and records the first mismatch.
module sp_mem_bist #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [AW-1:0]    fail_addr,
  output logic [WIDTH-1:0] fail_exp,
  output logic [WIDTH-1:0] fail_data,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [SW-1:0]    mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, CHECK, DONE
  } state_t;

  typedef struct packed {
    logic             cs;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [SW-1:0]    wstrb;
  } acc_t;

  function automatic acc_t wr_acc(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    acc_t r;
    r       = '0;
    r.cs    = 1'b1;
    r.we    = 1'b1;
    r.addr  = a;
    r.wdata = d;
    r.wstrb = '1;
    return r;
  endfunction

  function automatic acc_t rd_acc(input logic [AW-1:0] a);
    acc_t r;
    r      = '0;
    r.cs   = 1'b1;
    r.addr = a;
    return r;
  endfunction

  state_t           state, state_d;
  acc_t             acc_q, acc_d;
  logic [WIDTH-1:0] pat, pat_d;
  logic             cmp_valid, cmp_valid_d;
  logic [AW-1:0]    cmp_addr, cmp_addr_d;
  logic [WIDTH-1:0] cmp_exp, cmp_exp_d;
  logic             busy_d, done_d, fail_d;
  logic [AW-1:0]    fail_addr_d;
  logic [WIDTH-1:0] fail_exp_d, fail_data_d;
  logic             last_up, last_dn, mismatch;

  assign mem_cs    = acc_q.cs;
  assign mem_we    = acc_q.we;
  assign mem_addr  = acc_q.addr;
  assign mem_wdata = acc_q.wdata;
  assign mem_wstrb = acc_q.wstrb;

  assign last_up  = (acc_q.addr == AW'(DEPTH - 1));
  assign last_dn  = (acc_q.addr == '0);
  // Read data for the access sampled on the previous edge is on mem_rdata now.
  assign mismatch = cmp_valid && (mem_rdata != cmp_exp);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state;
    acc_d       = '0;
    pat_d       = pat;
    cmp_valid_d = 1'b0;
    cmp_addr_d  = cmp_addr;
    cmp_exp_d   = cmp_exp;
    busy_d      = busy;
    done_d      = done;
    fail_d      = fail;
    fail_addr_d = fail_addr;
    fail_exp_d  = fail_exp;
    fail_data_d = fail_data;

    if (state == M1_R || state == M2_R || state == M3_R) begin
      cmp_valid_d = 1'b1;
      cmp_addr_d  = acc_q.addr;
      cmp_exp_d   = (state == M2_R) ? ~pat : pat;
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = M0_W;
          pat_d       = pattern;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_data_d = '0;
          acc_d       = wr_acc('0, pattern);
        end
      end
      M0_W: begin
        if (last_up) begin
          state_d = M1_R;
          acc_d   = rd_acc('0);
        end else begin
          acc_d   = wr_acc(acc_q.addr + 1'b1, pat);
        end
      end
      M1_R: begin
        state_d = M1_W;
        acc_d   = wr_acc(acc_q.addr, ~pat);
      end
      M1_W: begin
        state_d = M2_R;
        acc_d   = rd_acc(last_up ? AW'(DEPTH - 1) : acc_q.addr + 1'b1);
        if (!last_up) state_d = M1_R;
      end
      M2_R: begin
        state_d = M2_W;
        acc_d   = wr_acc(acc_q.addr, pat);
      end
      M2_W: begin
        state_d = last_dn ? M3_R : M2_R;
        acc_d   = rd_acc(last_dn ? '0 : acc_q.addr - 1'b1);
      end
      M3_R: begin
        if (last_up) state_d = CHECK;
        else         acc_d   = rd_acc(acc_q.addr + 1'b1);
      end
      CHECK: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A mismatch aborts the sweep: the access already on the bus completes, nothing follows.
    if (mismatch) begin
      state_d     = DONE;
      acc_d       = '0;
      cmp_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr;
      fail_exp_d  = cmp_exp;
      fail_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_q     <= '0;
      pat       <= '0;
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
      cmp_exp   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_data <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state     <= state_d;
      acc_q     <= acc_d;
      pat       <= pat_d;
      cmp_valid <= cmp_valid_d;
      cmp_addr  <= cmp_addr_d;
      cmp_exp   <= cmp_exp_d;
      busy      <= busy_d;
      done      <= done_d;
      fail      <= fail_d;
      fail_addr <= fail_addr_d;
      fail_exp  <= fail_exp_d;
      fail_data <= fail_data_d;
    end
  end

endmodule

// File: tb/tb_sp_mem_bist.sv
// Directed bench for sp_mem_bist (WIDTH=32, DEPTH=16) against a behavioural single-port memory.
// Edges are numbered from the edge that accepts start (edge 0).
module tb_sp_mem_bist;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SW    = 4;
  localparam logic [WIDTH-1:0] PAT  = 32'hA5A5A5A5;
  localparam logic [WIDTH-1:0] NPAT = 32'h5A5A5A5A;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic             busy, done, fail;
  logic [AW-1:0]    fail_addr;
  logic [WIDTH-1:0] fail_exp, fail_data;
  logic             mem_cs, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [SW-1:0]    mem_wstrb;
  logic [WIDTH-1:0] mem_rdata;

  sp_mem_bist #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_data(fail_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory: byte-strobed writes, registered read data.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q = '0;
  logic [AW-1:0]    rd_addr_q = '0;
  logic             fault_on = 1'b0;

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < SW; b++)
          if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rdata_q   <= mem[mem_addr];
        rd_addr_q <= mem_addr;
      end
    end
  end

  assign mem_rdata = rdata_q ^ {31'b0, (fault_on && rd_addr_q == 4'd5)};

  // Bus monitor
  logic             track = 1'b0;
  int               edge_n = -1;
  int               cs_cnt, wr_cnt, cs_total, last_cs_edge;
  logic [AW-1:0]    acc_addr [128];
  logic             acc_we   [128];
  logic [WIDTH-1:0] rdv      [128];

  always @(posedge clk) begin
    if (mem_cs) cs_total++;
    if (track) begin
      edge_n++;
      if (edge_n >= 0 && edge_n < 128) begin
        acc_addr[edge_n] = mem_addr;
        acc_we[edge_n]   = mem_we;
        rdv[edge_n]      = mem_rdata;
      end
      if (mem_cs) begin
        cs_cnt++;
        if (mem_we) wr_cnt++;
        last_cs_edge = edge_n;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start        = 1'b1;
    track        = 1'b1;
    edge_n       = -1;
    cs_cnt       = 0;
    wr_cnt       = 0;
    last_cs_edge = -1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        at = edge_n;
        break;
      end
    end
  endtask

  int at;

  initial begin
    cs_total = 0;
    pattern  = PAT;

    // Reset held with start high
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_fail", 64'(fail), 64'(0));
    check("rst_bus", 64'({mem_cs, mem_we, mem_addr, mem_wstrb, mem_wdata}), 64'(0));
    check("rst_fail_info", 64'({fail_addr, fail_exp}), 64'(0));
    check("rst_fail_data", 64'(fail_data), 64'(0));
    start = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    cs_total = 0;
    repeat (5) @(negedge clk);
    check("idle_no_access", 64'(cs_total), 64'(0));

    // Clean run
    pulse_start();
    check("accept_busy", 64'(busy), 64'(1));
    wait_done(200, at);
    check("clean_done_edge", 64'(at), 64'(97));
    check("clean_fail", 64'(fail), 64'(0));
    check("clean_idle", 64'({busy, mem_cs}), 64'(0));
    check("clean_cs_cycles", 64'(cs_cnt), 64'(96));
    check("clean_writes", 64'(wr_cnt), 64'(48));
    check("first_access", 64'({acc_we[1], acc_addr[1]}), 64'({1'b1, 4'd0}));
    for (int k = 0; k < 2 * DEPTH; k++) begin
      check("m2_order", 64'({acc_we[49 + k], acc_addr[49 + k]}),
            64'({1'(k % 2), 4'(15 - k / 2)}));
      if (k % 2 == 0) check("m2_rdata", 64'(rdv[50 + k]), 64'(NPAT));
    end
    for (int a = 0; a < DEPTH; a++) check("mem_final", 64'(mem[a]), 64'(PAT));

    // Fault on reads of address 5
    fault_on = 1'b1;
    pulse_start();
    wait_done(200, at);
    check("fault_done_edge", 64'(at), 64'(28));
    check("fault_flags", 64'({fail, done, busy}), 64'(3'b110));
    check("fault_addr", 64'(fail_addr), 64'(5));
    check("fault_exp", 64'(fail_exp), 64'(PAT));
    check("fault_data", 64'(fail_data), 64'(32'hA5A5A5A4));
    repeat (10) @(negedge clk);
    check("fault_last_cs", 64'(last_cs_edge), 64'(28));
    fault_on = 1'b0;

    // Start during a run is ignored; start from DONE reruns
    pulse_start();
    check("restart_clears", 64'({done, fail, fail_addr}), 64'(0));
    while (edge_n < 9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, at);
    check("ignored_start_edge", 64'(at), 64'(97));
    pulse_start();
    check("done_falls", 64'({done, busy}), 64'(2'b01));
    wait_done(200, at);
    check("rerun_edge", 64'(at), 64'(97));
    check("rerun_fail", 64'(fail), 64'(0));

    // Reset during M2
    pulse_start();
    while (edge_n < 60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs", 64'(mem_cs), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    track    = 1'b0;
    rst_n    = 1'b1;
    cs_total = 0;
    repeat (4) @(negedge clk);
    check("midrst_no_access", 64'(cs_total), 64'(0));
    pulse_start();
    wait_done(200, at);
    check("midrst_rerun_edge", 64'(at), 64'(97));
    check("midrst_rerun_fail", 64'(fail), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
